// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder. Operands are captured in parallel on the
//   accepting edge. They are then shifted LSB-first through a single
//   full_adder cell, one bit per clock. The carry is recirculated through a
//   flip-flop into the cell's X input.
//
//   Parameters
//     WIDTH  operand/result width in bits (>= 1)
//
//   Ports
//     CLK    in   rising-edge clock
//     RST_N  in   asynchronous active-low reset
//     START  in   request, accepted only in IDLE
//     A, B   in   operands, sampled on the accepting edge only
//     CI     in   carry-in, sampled on the accepting edge only
//     BUSY   out  high while bits are being processed (RUN)
//     DONE   out  one-cycle pulse when S/CO hold a new result (FIN)
//     S      out  registered sum, (A+B+CI) mod 2^WIDTH
//     CO     out  registered carry-out, bit WIDTH of A+B+CI
//
//   Timing: START accepted on edge k -> BUSY after edges k..k+WIDTH-1,
//   DONE and new S/CO after edge k+WIDTH, back in IDLE after k+WIDTH+1.
// -----------------------------------------------------------------------------

// Existing one-bit full adder cell: S = A^B^X, C = carry out.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic X,
    output logic S,
    output logic C
);
    assign S = A ^ B ^ X;
    assign C = (A & B) | (X & (A ^ B));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             CO
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic             cy_q, cy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             co_q, co_d;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] top_bit;

    full_adder fa (
        .A (a_sh_q[0]),
        .B (b_sh_q[0]),
        .X (cy_q),
        .S (fa_s),
        .C (fa_c)
    );

    // Sum bit positioned at the MSB. Built this way so that WIDTH=1 needs no
    // special-case slice of s_sh.
    always_comb begin
        top_bit            = '0;
        top_bit[WIDTH-1]   = fa_s;
    end

    // NOTE: every signal driven here gets its default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        cy_d    = cy_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        co_d    = co_q;

        case (state_q)
            IDLE: begin
                if (START) begin
                    a_sh_d  = A;
                    b_sh_d  = B;
                    cy_d    = CI;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_sh_d = (s_sh_q >> 1) | top_bit;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                cy_d   = fa_c;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Last bit: the result registers take the completed sum
                    // and final carry on the same edge that enters FIN.
                    state_d = FIN;
                    s_d     = s_sh_d;
                    co_d    = fa_c;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the shift registers are ordinary flops, not a memory, so they are
    // cleared by reset along with everything else; a reset mid-run leaves no
    // partial operand or sum behind.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, regardless of statement order.
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            cy_q    <= cy_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            co_q    <= co_d;
        end
    end

    assign BUSY = (state_q == RUN);
    assign DONE = (state_q == FIN);
    assign S    = s_q;
    assign CO   = co_q;

endmodule
